// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
//   state_t          : sequencer FSM states
//   DEF_CMD_OPER     : default opcode of a full frame (opcode, A, B, FUN)
//   DEF_CMD_NOOPER   : default opcode of a short frame (opcode, FUN)
//   RESULT_BYTES     : number of bytes the ALU result is split into
package alu_seq_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned FUN_WIDTH      = 4;
  localparam int unsigned RESULT_BYTES   = 2;

  localparam logic [7:0] DEF_CMD_OPER   = 8'hCC;
  localparam logic [7:0] DEF_CMD_NOOPER = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_A    = 3'd1,
    ST_GET_B    = 3'd2,
    ST_GET_FUN  = 3'd3,
    ST_ALU_RUN  = 3'd4,
    ST_ALU_WAIT = 3'd5,
    ST_SEND_LO  = 3'd6,
    ST_SEND_HI  = 3'd7
  } state_t;

  // States in which a frame byte is expected and the timeout runs.
  function automatic logic is_get_state(input state_t s);
    return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_FUN);
  endfunction

  // States in which an incoming byte cannot be used and is dropped.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_ALU_RUN) || (s == ST_ALU_WAIT) ||
           (s == ST_SEND_LO) || (s == ST_SEND_HI);
  endfunction

endpackage

// File: rtl/alu_seq_frame_timer.sv
// Inter-byte timeout counter for frame reception.
//   CLK      : system clock, rising edge
//   RST      : synchronous active-high reset
//   clr      : clears the count (new state entry or accepted byte)
//   en       : count while a frame byte is awaited
//   expire_c : combinational, high in the cycle the count reaches TIMEOUT_CYC-1
module alu_seq_frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = en && (cnt_q == CNT_LAST);

  // Count saturates at the last value; the FSM leaves the GET state on expiry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer between the RX frame decoder, the shared ALU and the
// TX serializer. Parses opcode frames, loads ALU operands, fires ALU_EN,
// captures the result and returns it LSB first as two bytes.
//   CLK, RST               : clock, synchronous active-high reset
//   RX_DATA, RX_VALID      : received byte stream
//   ALU_A, ALU_B, ALU_FUN  : registered ALU operands / function
//   ALU_EN                 : one-cycle ALU enable
//   ALU_OUT, ALU_OUT_VALID : ALU result and (sticky) valid
//   TX_DATA, TX_VALID      : result bytes to transmitter, held until accepted
//   TX_BUSY                : transmitter backpressure
//   CTRL_BUSY              : high whenever not idle
//   CMD_ERR                : pulse on bad opcode, frame timeout, missing result
//   RX_DROP                : pulse on a byte arriving while none is expected
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [DATA_WIDTH-1:0] CMD_OPER   = DATA_WIDTH'(DEF_CMD_OPER),
  parameter logic [DATA_WIDTH-1:0] CMD_NOOPER = DATA_WIDTH'(DEF_CMD_NOOPER),
  localparam int unsigned OUT_WIDTH = RESULT_BYTES * DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_BUSY,
  output logic                  CTRL_BUSY,
  output logic                  CMD_ERR,
  output logic                  RX_DROP
);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] alu_a_d, alu_b_d, tx_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_d;
  logic [OUT_WIDTH-1:0]  result_q, result_d;
  logic alu_en_d, tx_valid_d, ctrl_busy_d, cmd_err_d, rx_drop_d;

  logic in_get_c, tmr_clr_c, tmr_expire_c, tx_xfer_c;

  assign in_get_c  = is_get_state(state_q);
  // Clearing outside GET states makes every GET entry start from zero.
  assign tmr_clr_c = !in_get_c || RX_VALID;
  assign tx_xfer_c = TX_VALID && !TX_BUSY;

  alu_seq_frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (tmr_clr_c),
    .en       (in_get_c),
    .expire_c (tmr_expire_c)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = ALU_A;
    alu_b_d    = ALU_B;
    alu_fun_d  = ALU_FUN;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    rx_drop_d  = 1'b0;
    result_d   = result_q;
    tx_data_d  = TX_DATA;
    tx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA == CMD_OPER) begin
            state_d = ST_GET_A;
          end else if (RX_DATA == CMD_NOOPER) begin
            state_d = ST_GET_FUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      // An arriving byte takes priority over a coincident timeout.
      ST_GET_A: begin
        if (RX_VALID) begin
          alu_a_d = RX_DATA;
          state_d = ST_GET_B;
        end else if (tmr_expire_c) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_GET_B: begin
        if (RX_VALID) begin
          alu_b_d = RX_DATA;
          state_d = ST_GET_FUN;
        end else if (tmr_expire_c) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_GET_FUN: begin
        if (RX_VALID) begin
          alu_fun_d = RX_DATA[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_RUN;
        end else if (tmr_expire_c) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ALU_RUN: begin
        state_d = ST_ALU_WAIT;
      end
      // OUT_VALID is sticky in the ALU, so it is only meaningful here.
      ST_ALU_WAIT: begin
        if (ALU_OUT_VALID) begin
          result_d = ALU_OUT;
          state_d  = ST_SEND_LO;
        end else begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_SEND_LO: begin
        if (tx_xfer_c) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (tx_xfer_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (RX_VALID && is_busy_state(state_q)) begin
      rx_drop_d = 1'b1;
    end

    // TX byte mux follows the state being entered, so TX_DATA is stable
    // for as long as a send state is held under backpressure.
    case (state_d)
      ST_SEND_LO: begin
        tx_valid_d = 1'b1;
        tx_data_d  = result_d[DATA_WIDTH-1:0];
      end
      ST_SEND_HI: begin
        tx_valid_d = 1'b1;
        tx_data_d  = result_d[OUT_WIDTH-1 -: DATA_WIDTH];
      end
      default: begin
        tx_valid_d = 1'b0;
      end
    endcase

    ctrl_busy_d = (state_d != ST_IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      TX_DATA   <= '0;
      TX_VALID  <= 1'b0;
      CTRL_BUSY <= 1'b0;
      CMD_ERR   <= 1'b0;
      RX_DROP   <= 1'b0;
      result_q  <= '0;
    end else begin
      ALU_A     <= alu_a_d;
      ALU_B     <= alu_b_d;
      ALU_FUN   <= alu_fun_d;
      ALU_EN    <= alu_en_d;
      TX_DATA   <= tx_data_d;
      TX_VALID  <= tx_valid_d;
      CTRL_BUSY <= ctrl_busy_d;
      CMD_ERR   <= cmd_err_d;
      RX_DROP   <= rx_drop_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and a TX
// byte scoreboard.
module tb_alu_seq_ctrl;

  localparam int unsigned TMO = 1024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic [7:0]  ALU_A, ALU_B, TX_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_VALID, CTRL_BUSY, CMD_ERR, RX_DROP;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        TX_BUSY = 1'b0;

  logic        alu_vld_q;
  logic        alu_kill = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt = 0, err_cnt = 0, drop_cnt = 0, xfer_cnt = 0;
  int last_err_cyc = 0;
  logic [7:0] exp_q[$];

  alu_seq_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_DATA       (RX_DATA),
    .RX_VALID      (RX_VALID),
    .ALU_A         (ALU_A),
    .ALU_B         (ALU_B),
    .ALU_FUN       (ALU_FUN),
    .ALU_EN        (ALU_EN),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VALID (ALU_OUT_VALID),
    .TX_DATA       (TX_DATA),
    .TX_VALID      (TX_VALID),
    .TX_BUSY       (TX_BUSY),
    .CTRL_BUSY     (CTRL_BUSY),
    .CMD_ERR       (CMD_ERR),
    .RX_DROP       (RX_DROP)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Behavioural ALU: one-cycle latency, sticky valid.
  always @(posedge CLK) begin
    if (RST) begin
      ALU_OUT   <= '0;
      alu_vld_q <= 1'b0;
    end else if (ALU_EN) begin
      alu_vld_q <= 1'b1;
      case (ALU_FUN)
        4'd0:    ALU_OUT <= 16'(ALU_A) + 16'(ALU_B);
        4'd1:    ALU_OUT <= 16'(ALU_A) - 16'(ALU_B);
        4'd2:    ALU_OUT <= 16'(ALU_A) * 16'(ALU_B);
        default: ALU_OUT <= 16'h0000;
      endcase
    end
  end
  assign ALU_OUT_VALID = alu_vld_q && !alu_kill;

  // Monitor: pulse counters and TX scoreboard.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ALU_EN) en_cnt++;
      if (CMD_ERR) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (RX_DROP) drop_cnt++;
      if (TX_VALID && !TX_BUSY) begin
        xfer_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: got %02h, none expected", TX_DATA);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (TX_DATA !== e) begin
            n_bad++;
            $display("FAIL tx_byte: got %02h, expected %02h", TX_DATA, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send4(input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] f);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (exp_q.size() == 0 && !CTRL_BUSY && !TX_VALID) begin
        done = 1;
        break;
      end
    end
    check({name, "_idle"}, 64'(done), 64'd1);
  endtask

  task automatic wait_tx_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      if (TX_VALID) begin
        seen = 1;
        break;
      end
    end
    check({name, "_tx_valid"}, 64'(seen), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_VALID,
                 CMD_ERR, RX_DROP, CTRL_BUSY}, 64'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, d0, x0, en0, c0, lat, bad_hold;

    // Reset state
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK); #1;
    check_all_zero("reset_outputs");

    // Full multiply 7*5 = 0x0023, with latency check
    en0 = en_cnt;
    exp_q.push_back(8'h23); exp_q.push_back(8'h00);
    send4(8'hCC, 8'h07, 8'h05, 8'h02);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      if (TX_VALID) break;
      @(posedge CLK);
      lat++;
    end
    check("frame_latency", 64'(lat), 64'd3);
    check("mul_operands", {ALU_A, ALU_B, ALU_FUN}, {8'h07, 8'h05, 4'h2});
    wait_idle("mul");
    check("mul_en_pulses", 64'(en_cnt - en0), 64'd1);
    check("mul_busy_low", 64'(CTRL_BUSY), 64'd0);

    // Short frame reuses A=7, B=5, FUN=1: 7-5 = 0x0002
    exp_q.push_back(8'h02); exp_q.push_back(8'h00);
    send_byte(8'hDD);
    send_byte(8'h01);
    wait_idle("short");
    check("short_operands", {ALU_A, ALU_B, ALU_FUN}, {8'h07, 8'h05, 4'h1});

    // Wrap subtraction 3-5 = 0xFFFE
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    send4(8'hCC, 8'h03, 8'h05, 8'h01);
    wait_idle("wrap");

    // Backpressure: 4*3 = 0x000C held 20 cycles, one RX byte dropped
    TX_BUSY = 1'b1;
    exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
    send4(8'hCC, 8'h04, 8'h03, 8'h02);
    wait_tx_valid("bp");
    d0 = drop_cnt; e0 = err_cnt; x0 = xfer_cnt;
    bad_hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      RX_DATA  = 8'h77;
      RX_VALID = (i == 5);
      @(negedge CLK); #1;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'h0C || CTRL_BUSY !== 1'b1) bad_hold++;
    end
    RX_VALID = 1'b0;
    check("bp_hold_bad_cycles", 64'(bad_hold), 64'd0);
    check("bp_rx_drop", 64'(drop_cnt - d0), 64'd1);
    check("bp_no_err", 64'(err_cnt - e0), 64'd0);
    @(posedge CLK); #1 TX_BUSY = 1'b0;
    wait_idle("bp");
    check("bp_transfers", 64'(xfer_cnt - x0), 64'd2);

    // Unknown opcode
    e0 = err_cnt;
    send_byte(8'h5A);
    repeat (2) begin @(negedge CLK); #1; end
    check("bad_opcode_err", 64'(err_cnt - e0), 64'd1);
    check("bad_opcode_idle", 64'(CTRL_BUSY), 64'd0);

    // Frame timeout after CC,11
    e0 = err_cnt;
    send_byte(8'hCC);
    send_byte(8'h11);
    c0 = cyc;
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge CLK); #1;
      if (err_cnt != e0) break;
    end
    check("timeout_err", 64'(err_cnt - e0), 64'd1);
    check("timeout_cycles", 64'(last_err_cyc - c0), 64'(TMO));
    @(negedge CLK); #1;
    check("timeout_idle", 64'(CTRL_BUSY), 64'd0);
    check("timeout_partial_a", 64'(ALU_A), 64'h11);

    // Missing ALU result
    alu_kill = 1'b1;
    e0 = err_cnt; x0 = xfer_cnt;
    send4(8'hCC, 8'h01, 8'h01, 8'h00);
    repeat (5) begin @(negedge CLK); #1; end
    check("no_result_err", 64'(err_cnt - e0), 64'd1);
    check("no_result_no_tx", 64'(xfer_cnt - x0), 64'd0);
    check("no_result_idle", 64'(CTRL_BUSY), 64'd0);
    alu_kill = 1'b0;

    // Byte arriving in the expiry cycle wins: 9*3 = 0x001B
    e0 = err_cnt;
    exp_q.push_back(8'h1B); exp_q.push_back(8'h00);
    send_byte(8'hCC);
    repeat (TMO - 2) @(posedge CLK);
    send_byte(8'h09);
    send_byte(8'h03);
    send_byte(8'h02);
    wait_idle("edge_byte");
    check("edge_byte_no_err", 64'(err_cnt - e0), 64'd0);
    check("edge_byte_operands", {ALU_A, ALU_B}, {8'h09, 8'h03});

    // Reset during SEND_HI, then a fresh frame 2+2 = 0x0004
    TX_BUSY = 1'b1;
    exp_q.push_back(8'h0C);
    send4(8'hCC, 8'h06, 8'h02, 8'h02);
    wait_tx_valid("rst_send");
    @(posedge CLK); #1 TX_BUSY = 1'b0;
    @(posedge CLK); #1 TX_BUSY = 1'b1;
    @(negedge CLK); #1;
    check("send_hi_pending", {TX_VALID, TX_DATA, CTRL_BUSY}, {1'b1, 8'h00, 1'b1});
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    TX_BUSY = 1'b0;
    @(negedge CLK); #1;
    check_all_zero("midsend_reset_outputs");
    exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    send4(8'hCC, 8'h02, 8'h02, 8'h00);
    wait_idle("post_reset");

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
